lc_key_decoder: RTL and testbench

- Sits directly downstream of the PS/2 keyboard driver and consumes its completed scan-code bytes.
- Parses the make, break (F0) and extended (E0) prefix sequences.
- Maps WASD keys to player 1 and arrow keys to player 2, queuing legal turns per player.
- Releases one queued turn per player on each game tick to the light-cycle movement logic.

---
 rtl/lc_pkg.sv | 36 +++
 rtl/lc_dir_queue.sv | 69 ++++++
 rtl/lc_key_decoder.sv | 163 ++++++++++++++++
 tb/tb_lc_key_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_pkg.sv
// Shared types and constants for the light-cycle keyboard decoder.
// Scan codes are PS/2 set 2; SC_P is only decoded when LC_PAUSE_KEY_EN is defined.
package lc_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_A  = 8'h1C;
  localparam logic [7:0] SC_S  = 8'h1B;
  localparam logic [7:0] SC_D  = 8'h23;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DN = 8'h72;
  localparam logic [7:0] SC_LT = 8'h6B;
  localparam logic [7:0] SC_RT = 8'h74;
  localparam logic [7:0] SC_P  = 8'h4D;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } parse_state_t;

  // A turn is legal unless it repeats the reference or reverses it by 180 degrees.
  function automatic logic legalTurn(input dir_t newDir, input dir_t refDir);
    return (newDir != refDir) && ((newDir ^ refDir) != 2'b10);
  endfunction

endpackage

// File: rtl/lc_dir_queue.sv
// Per-player pending-turn queue with duplicate/reversal filtering.
// A pop on the same cycle as a push happens first and frees a slot for it.
module lc_dir_queue
  import lc_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter dir_t        INIT_DIR = DIR_RIGHT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pushValid,
  input  dir_t pushDir,
  input  logic popReq,
  output dir_t dir,
  output logic turn,
  output logic drop_c
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  dir_t             q     [QDEPTH];
  dir_t             nextQ [QDEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nextCount;
  logic             popNow;
  dir_t             refDir;

  // Pop, then evaluate the push against the post-pop tail (or popped head).
  always_comb begin
    nextQ     = q;
    nextCount = count;
    refDir    = dir;
    drop_c    = 1'b0;
    popNow    = popReq && (count != '0);
    if (popNow) begin
      refDir = q[0];
      for (int i = 0; i < int'(QDEPTH) - 1; i++) nextQ[i] = q[i+1];
      nextCount = count - CNT_W'(1);
    end
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (int'(nextCount) == i + 1) refDir = nextQ[i];
    end
    if (pushValid && legalTurn(pushDir, refDir)) begin
      if (int'(nextCount) == int'(QDEPTH)) begin
        drop_c = 1'b1;
      end else begin
        for (int i = 0; i < int'(QDEPTH); i++) begin
          if (int'(nextCount) == i) nextQ[i] = pushDir;
        end
        nextCount = nextCount + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) q[i] <= DIR_UP;
      count <= '0;
      dir   <= INIT_DIR;
      turn  <= 1'b0;
    end else begin
      q     <= nextQ;
      count <= nextCount;
      turn  <= popNow;
      if (popNow) dir <= q[0];
    end
  end

endmodule

// File: rtl/lc_key_decoder.sv
// PS/2 scan-code parser feeding two per-player turn queues, released on game_tick.
// Optional macro LC_PAUSE_KEY_EN: the "P" make toggles pause, which freezes tick pops.
module lc_key_decoder
  import lc_pkg::*;
#(
  parameter int unsigned QDEPTH         = 2,
  parameter int unsigned PREFIX_TIMEOUT = 2000000,
  parameter logic [1:0]  P1_INIT_DIR    = 2'd1,
  parameter logic [1:0]  P2_INIT_DIR    = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  input  logic       game_tick,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic       ovf,
  output logic       pause
);

  localparam int unsigned TO_W = $clog2(PREFIX_TIMEOUT + 1);

  parse_state_t    state;
  parse_state_t    nextState;
  logic [TO_W-1:0] toCnt;
  logic [TO_W-1:0] nextToCnt;
  logic            rstDone;
  logic            codeValid;
  logic            tickGated;
  logic            p1Push;
  logic            p2Push;
  dir_t            p1New;
  dir_t            p2New;
  logic            p1Drop;
  logic            p2Drop;

  // The first edge after reset release is masked so a coincident byte is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstDone <= 1'b0;
    else        rstDone <= 1'b1;
  end

  assign codeValid = code_valid && rstDone;

`ifdef LC_PAUSE_KEY_EN
  logic pauseToggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pause <= 1'b0;
    else if (pauseToggle) pause <= ~pause;
  end

  assign tickGated = game_tick && !pause;
`else
  assign pause     = 1'b0;
  assign tickGated = game_tick;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PS_IDLE;
      toCnt <= '0;
    end else begin
      state <= nextState;
      toCnt <= nextToCnt;
    end
  end

  // Prefix parser with timeout back to IDLE; emits one push per mapped make.
  always_comb begin
    nextState = state;
    nextToCnt = toCnt;
    p1Push    = 1'b0;
    p2Push    = 1'b0;
    p1New     = DIR_UP;
    p2New     = DIR_UP;
`ifdef LC_PAUSE_KEY_EN
    pauseToggle = 1'b0;
`endif
    if (codeValid) begin
      nextToCnt = '0;
      case (state)
        PS_IDLE: begin
          if (code_in == SC_E0)      nextState = PS_EXT;
          else if (code_in == SC_F0) nextState = PS_BRK;
          else begin
            case (code_in)
              SC_W:    begin p1Push = 1'b1; p1New = DIR_UP;    end
              SC_D:    begin p1Push = 1'b1; p1New = DIR_RIGHT; end
              SC_S:    begin p1Push = 1'b1; p1New = DIR_DOWN;  end
              SC_A:    begin p1Push = 1'b1; p1New = DIR_LEFT;  end
`ifdef LC_PAUSE_KEY_EN
              SC_P:    pauseToggle = 1'b1;
`endif
              default: ;
            endcase
          end
        end
        PS_EXT: begin
          if (code_in == SC_F0)      nextState = PS_EXT_BRK;
          else if (code_in == SC_E0) nextState = PS_EXT;
          else begin
            nextState = PS_IDLE;
            case (code_in)
              SC_UP:   begin p2Push = 1'b1; p2New = DIR_UP;    end
              SC_RT:   begin p2Push = 1'b1; p2New = DIR_RIGHT; end
              SC_DN:   begin p2Push = 1'b1; p2New = DIR_DOWN;  end
              SC_LT:   begin p2Push = 1'b1; p2New = DIR_LEFT;  end
              default: ;
            endcase
          end
        end
        PS_BRK, PS_EXT_BRK: nextState = PS_IDLE;
        default:            nextState = PS_IDLE;
      endcase
    end else if (state != PS_IDLE) begin
      if (toCnt == TO_W'(PREFIX_TIMEOUT - 1)) begin
        nextState = PS_IDLE;
        nextToCnt = '0;
      end else begin
        nextToCnt = toCnt + TO_W'(1);
      end
    end
  end

  lc_dir_queue #(
    .QDEPTH   (QDEPTH),
    .INIT_DIR (P1_INIT_DIR)
  ) u_p1Queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (p1Push),
    .pushDir   (p1New),
    .popReq    (tickGated),
    .dir       (p1_dir),
    .turn      (p1_turn),
    .drop_c    (p1Drop)
  );

  lc_dir_queue #(
    .QDEPTH   (QDEPTH),
    .INIT_DIR (P2_INIT_DIR)
  ) u_p2Queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (p2Push),
    .pushDir   (p2New),
    .popReq    (tickGated),
    .dir       (p2_dir),
    .turn      (p2_turn),
    .drop_c    (p2Drop)
  );

  // Sticky overflow; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (p1Drop || p2Drop)  ovf <= 1'b1;
  end

endmodule

// File: tb/tb_lc_key_decoder.sv
// Directed bench for lc_key_decoder; define LC_PAUSE_KEY_EN to cover the pause key.
module tb_lc_key_decoder;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code_in;
  logic       code_valid;
  logic       game_tick;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       p1_turn;
  logic       p2_turn;
  logic       ovf;
  logic       pause;

  int vectors = 0;
  int miscompares = 0;

  lc_key_decoder #(
    .QDEPTH         (2),
    .PREFIX_TIMEOUT (TO),
    .P1_INIT_DIR    (2'd1),
    .P2_INIT_DIR    (2'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .game_tick  (game_tick),
    .p1_dir     (p1_dir),
    .p2_dir     (p2_dir),
    .p1_turn    (p1_turn),
    .p2_turn    (p2_turn),
    .ovf        (ovf),
    .pause      (pause)
  );

  always #5 clk = ~clk;

  // All drivers are entered on a negedge and return on the next negedge.
  task automatic sendByte(input logic [7:0] b);
    code_in = b; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic doTick();
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic tickWithByte(input logic [7:0] b);
    game_tick = 1'b1; code_in = b; code_valid = 1'b1;
    @(negedge clk);
    game_tick = 1'b0; code_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; code_valid = 1'b0; game_tick = 1'b0; code_in = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if ({p1_dir, p2_dir, p1_turn, p2_turn, ovf, pause} !== {2'd1, 2'd3, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_values got p1=%0d p2=%0d t1=%b t2=%b ovf=%b pause=%b want 1 3 0 0 0 0",
               p1_dir, p2_dir, p1_turn, p2_turn, ovf, pause);
    end
    // Byte presented on the release cycle must be ignored.
    code_in = 8'h1D; code_valid = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_byte got p1=%0d t1=%b want 1 0", p1_dir, p1_turn);
    end
  endtask

  task automatic test_p1_make();
    sendByte(8'h1D);
    doTick();
    vectors++;
    if (p1_dir !== 2'd0 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL p1_make got p1=%0d t1=%b want 0 1", p1_dir, p1_turn);
    end
    vectors++;
    if (p2_dir !== 2'd3 || p2_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL p1_make_p2_idle got p2=%0d t2=%b want 3 0", p2_dir, p2_turn);
    end
    @(negedge clk);
    vectors++;
    if (p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL p1_turn_width got t1=%b want 0", p1_turn);
    end
  endtask

  task automatic test_reversal();
    sendByte(8'h23);
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL p1_right got p1=%0d t1=%b want 1 1", p1_dir, p1_turn);
    end
    sendByte(8'h1C);
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL reversal_reject got p1=%0d t1=%b want 1 0", p1_dir, p1_turn);
    end
    sendByte(8'h23);
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL duplicate_reject got p1=%0d t1=%b want 1 0", p1_dir, p1_turn);
    end
  endtask

  task automatic test_p2_ext_break();
    sendByte(8'hE0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    doTick();
    vectors++;
    if (p2_dir !== 2'd0 || p2_turn !== 1'b1 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL p2_ext_make got p2=%0d t2=%b t1=%b want 0 1 0", p2_dir, p2_turn, p1_turn);
    end
    doTick();
    vectors++;
    if (p2_dir !== 2'd0 || p2_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL p2_break_no_effect got p2=%0d t2=%b want 0 0", p2_dir, p2_turn);
    end
    // 75 without E0 is an unmapped normal code.
    sendByte(8'h75); sendByte(8'h74);
    doTick();
    vectors++;
    if (p2_dir !== 2'd0 || p2_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL p2_needs_e0 got p2=%0d t2=%b want 0 0", p2_dir, p2_turn);
    end
  endtask

  task automatic test_back_to_back();
    // p1=RIGHT; queue DOWN, then tick+UP: post-pop reference is DOWN, UP is a reversal.
    sendByte(8'h1B);
    tickWithByte(8'h1D);
    vectors++;
    if (p1_dir !== 2'd2 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pop got p1=%0d t1=%b want 2 1", p1_dir, p1_turn);
    end
    doTick();
    vectors++;
    if (p1_dir !== 2'd2 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_postpop_reversal got p1=%0d t1=%b want 2 0", p1_dir, p1_turn);
    end
    // Queue LEFT, then tick+UP: legal against popped LEFT.
    sendByte(8'h1C);
    tickWithByte(8'h1D);
    doTick();
    vectors++;
    if (p1_dir !== 2'd0 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept got p1=%0d t1=%b want 0 1", p1_dir, p1_turn);
    end
    // Full queue (RIGHT, DOWN) plus tick+LEFT: pop frees the slot, no overflow.
    sendByte(8'h23); sendByte(8'h1B);
    tickWithByte(8'h1C);
    vectors++;
    if (p1_dir !== 2'd1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full_push got p1=%0d ovf=%b want 1 0", p1_dir, ovf);
    end
    doTick();
    doTick();
    vectors++;
    if (p1_dir !== 2'd3 || p1_turn !== 1'b1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full_drain got p1=%0d t1=%b ovf=%b want 3 1 0", p1_dir, p1_turn, ovf);
    end
  endtask

  task automatic test_overflow();
    // p1=LEFT: UP, RIGHT fill the queue; DOWN is dropped.
    sendByte(8'h1D); sendByte(8'h23); sendByte(8'h1B);
    @(negedge clk);
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set got ovf=%b want 1", ovf);
    end
    doTick();
    vectors++;
    if (p1_dir !== 2'd0 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_tick1 got p1=%0d t1=%b want 0 1", p1_dir, p1_turn);
    end
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_tick2 got p1=%0d t1=%b want 1 1", p1_dir, p1_turn);
    end
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_dropped got p1=%0d t1=%b ovf=%b want 1 0 1", p1_dir, p1_turn, ovf);
    end
  endtask

  task automatic test_timeout();
    // One cycle short of the timeout: 1D is still taken as an extended code.
    sendByte(8'hE0);
    repeat (TO - 1) @(negedge clk);
    sendByte(8'h1D);
    doTick();
    vectors++;
    if (p1_dir !== 2'd1 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_not_yet got p1=%0d t1=%b want 1 0", p1_dir, p1_turn);
    end
    sendByte(8'hE0);
    repeat (TO) @(negedge clk);
    sendByte(8'h1D);
    doTick();
    vectors++;
    if (p1_dir !== 2'd0 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_idle got p1=%0d t1=%b want 0 1", p1_dir, p1_turn);
    end
  endtask

  task automatic test_pause();
`ifdef LC_PAUSE_KEY_EN
    sendByte(8'h4D);
    vectors++;
    if (pause !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_on got pause=%b want 1", pause);
    end
    sendByte(8'h1C);
    doTick();
    vectors++;
    if (p1_dir !== 2'd0 || p1_turn !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_hold got p1=%0d t1=%b want 0 0", p1_dir, p1_turn);
    end
    sendByte(8'hF0); sendByte(8'h4D);
    vectors++;
    if (pause !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_break got pause=%b want 1", pause);
    end
    sendByte(8'h4D);
    doTick();
    vectors++;
    if (pause !== 1'b0 || p1_dir !== 2'd3 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_off got pause=%b p1=%0d t1=%b want 0 3 1", pause, p1_dir, p1_turn);
    end
`else
    sendByte(8'h4D);
    sendByte(8'h1C);
    doTick();
    vectors++;
    if (pause !== 1'b0 || p1_dir !== 2'd3 || p1_turn !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_absent got pause=%b p1=%0d t1=%b want 0 3 1", pause, p1_dir, p1_turn);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_p1_make();
    test_reversal();
    test_p2_ext_break();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_pause();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
